// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and widths for the run controller.
//   run_state_t : controller FSM state encoding
//   CYC_W       : width of the RUN cycle counter
//   ADDR_W      : data-memory address width
//   DATA_W      : data-memory read data / checksum width
package run_ctrl_pkg;

  localparam int unsigned CYC_W  = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    REQ,
    RUN,
    DUMP,
    DONE
  } run_state_t;

endpackage

// File: rtl/run_ctrl_timer.sv
// run_timer: saturating RUN cycle counter.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, has priority over en
//   en    : increment request; the count holds at all-ones
//   count : current count
//   tc    : high while count equals TERM
module run_timer
  import run_ctrl_pkg::*;
#(
  parameter logic [CYC_W-1:0] TERM = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TERM);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences one program run on a core: holds the core in reset,
// pulses req, counts RUN cycles until done or timeout, optionally reads back
// a data-memory window and XORs it into a checksum.
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset
//   start       : host request to run one program (IDLE/DONE only)
//   cpu_done    : core done flag (sampled in RUN only)
//   cpu_req     : core req input, one cycle in REQ
//   cpu_rst     : core active-high synchronous reset
//   mem_addr    : data-memory read address (RD_BASE outside DUMP)
//   mem_rd_data : asynchronous read data for mem_addr
//   busy        : high in RST, REQ, RUN, DUMP
//   finished    : high in DONE
//   timed_out   : last run hit TIMEOUT
//   cycles      : RUN cycle count of the last run
//   checksum    : XOR of the read-back bytes
// Build option: define RUN_CTRL_CHECKSUM_EN to include the DUMP read-back;
// otherwise checksum is 0 and mem_addr stays at RD_BASE.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter logic [CYC_W-1:0]  TIMEOUT = 16'd50000,
  parameter logic [ADDR_W-1:0] RD_BASE = 8'd0,
  parameter logic [ADDR_W-1:0] RD_LEN  = 8'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_done,
  output logic              cpu_req,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CYC_W-1:0]  cycles,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [CYC_W-1:0] TERM = TIMEOUT - CYC_W'(1);

  run_state_t state, state_nxt;
  logic       rst_second;
  logic       tc;

  run_timer #(
    .TERM (TERM)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state == REQ),
    .en    ((state == RUN) && !cpu_done),
    .count (cycles),
    .tc    (tc)
  );

`ifdef RUN_CTRL_CHECKSUM_EN
  // RD_LEN of 0 wraps to 256 bytes: last address is RD_BASE - 1.
  localparam logic [ADDR_W-1:0] LAST_ADDR = RD_BASE + RD_LEN - ADDR_W'(1);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RST;
      RST:     if (rst_second) state_nxt = REQ;
      REQ:     state_nxt = RUN;
      RUN: begin
        // done wins over the terminal count in the same cycle
        if (cpu_done) begin
`ifdef RUN_CTRL_CHECKSUM_EN
          state_nxt = DUMP;
`else
          state_nxt = DONE;
`endif
        end else if (tc) begin
          state_nxt = DONE;
        end
      end
`ifdef RUN_CTRL_CHECKSUM_EN
      DUMP:    if (mem_addr == LAST_ADDR) state_nxt = DONE;
`endif
      DONE:    if (start) state_nxt = RST;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rst_second <= 1'b0;
      cpu_rst    <= 1'b1;
      cpu_req    <= 1'b0;
      busy       <= 1'b0;
      finished   <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rst_second <= (state == RST) && !rst_second;
      cpu_rst    <= (state_nxt == IDLE) || (state_nxt == RST) || (state_nxt == DONE);
      cpu_req    <= (state_nxt == REQ);
      busy       <= (state_nxt != IDLE) && (state_nxt != DONE);
      finished   <= (state_nxt == DONE);
      if (state == REQ) begin
        timed_out <= 1'b0;
      end else if ((state == RUN) && !cpu_done && tc) begin
        timed_out <= 1'b1;
      end
    end
  end

`ifdef RUN_CTRL_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= RD_BASE;
      checksum <= '0;
    end else begin
      if (state == REQ) begin
        checksum <= '0;
      end else if (state == DUMP) begin
        checksum <= checksum ^ mem_rd_data;
      end
      if ((state == DUMP) && (mem_addr != LAST_ADDR)) begin
        mem_addr <= mem_addr + 1'b1;
      end else begin
        mem_addr <= RD_BASE;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{mem_rd_data, RD_LEN};
  assign mem_addr  = RD_BASE;
  assign checksum  = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl. Two instances share clk/reset:
// u_dut0 with default parameters (identity memory), u_dut1 with TIMEOUT=20,
// RD_BASE=F0, RD_LEN=32 and a sparse memory whose in-window XOR is FF.
// Expectations follow RUN_CTRL_CHECKSUM_EN as seen by this file.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

`ifdef RUN_CTRL_CHECKSUM_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, done0, req0, crst0, busy0, fin0, to0;
  logic        start1, done1, req1, crst1, busy1, fin1, to1;
  logic [7:0]  addr0, rd0, sum0, addr1, rd1, sum1;
  logic [15:0] cyc0, cyc1;

  run_ctrl u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .cpu_done(done0),
    .cpu_req(req0), .cpu_rst(crst0), .mem_addr(addr0), .mem_rd_data(rd0),
    .busy(busy0), .finished(fin0), .timed_out(to0), .cycles(cyc0),
    .checksum(sum0)
  );

  run_ctrl #(
    .TIMEOUT (16'd20),
    .RD_BASE (8'hF0),
    .RD_LEN  (8'd32)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .cpu_done(done1),
    .cpu_req(req1), .cpu_rst(crst1), .mem_addr(addr1), .mem_rd_data(rd1),
    .busy(busy1), .finished(fin1), .timed_out(to1), .cycles(cyc1),
    .checksum(sum1)
  );

  assign rd0 = addr0;

  // Window F0..0F holds 11,22,44,88 (XOR = FF); EF and 10 sit just outside.
  always_comb begin
    case (addr1)
      8'hF0:   rd1 = 8'h11;
      8'hFF:   rd1 = 8'h22;
      8'h00:   rd1 = 8'h44;
      8'h0F:   rd1 = 8'h88;
      8'hEF:   rd1 = 8'hFF;
      8'h10:   rd1 = 8'hFF;
      default: rd1 = 8'h00;
    endcase
  end

  typedef struct packed {
    logic        req, rst, busy, fin, to;
    logic [15:0] cyc;
    logic [7:0]  sum, addr;
  } obs_t;

  typedef struct {
    int          d;
    int          done_at;   // RUN cycle index with cpu_done high, -1 = never
    logic [15:0] exp_cyc;
    logic        exp_to;
    logic [7:0]  exp_sum;
    int          exp_dump;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    if (d == 0) begin
      o.req = req0; o.rst = crst0; o.busy = busy0; o.fin = fin0; o.to = to0;
      o.cyc = cyc0; o.sum = sum0; o.addr = addr0;
    end else begin
      o.req = req1; o.rst = crst1; o.busy = busy1; o.fin = fin1; o.to = to1;
      o.cyc = cyc1; o.sum = sum1; o.addr = addr1;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start0 = v; else start1 = v;
  endtask

  task automatic set_done(input int d, input logic v);
    if (d == 0) done0 = v; else done1 = v;
  endtask

  // Called at a negedge; returns at the negedge of the REQ cycle.
  task automatic start_and_wait_req(input int d, output bit ok);
    obs_t o;
    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      o = get_obs(d);
      if (o.req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag, input int d, input logic [7:0] base);
    obs_t o;
    o = get_obs(d);
    check({tag, "_req"},  o.req,  1'b0);
    check({tag, "_rst"},  o.rst,  1'b1);
    check({tag, "_busy"}, o.busy, 1'b0);
    check({tag, "_fin"},  o.fin,  1'b0);
    check({tag, "_to"},   o.to,   1'b0);
    check({tag, "_cyc"},  o.cyc,  16'd0);
    check({tag, "_sum"},  o.sum,  8'h00);
    check({tag, "_addr"}, o.addr, base);
  endtask

  vec_t vecs[7];

  initial begin
    obs_t o;
    bit   ok;
    bit   ended;
    int   n;
    int   reqs;

    reset = 1'b0;
    start0 = 1'b0; done0 = 1'b0; start1 = 1'b0; done1 = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst0", 0, 8'h00);
    check_reset_vals("rst1", 1, 8'hF0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_hold_busy0", busy0, 1'b0);
    check("idle_hold_rst0", crst0, 1'b1);

    // ---- handshake: 2 cpu_rst cycles, 1 req cycle, then RUN ----
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("hs_rst1_busy", busy0, 1'b1);
    check("hs_rst1_rst", crst0, 1'b1);
    check("hs_rst1_req", req0, 1'b0);
    @(negedge clk);
    check("hs_rst2_rst", crst0, 1'b1);
    check("hs_rst2_req", req0, 1'b0);
    @(negedge clk);
    check("hs_req_rst", crst0, 1'b0);
    check("hs_req_req", req0, 1'b1);
    @(negedge clk);
    check("hs_run_req", req0, 1'b0);
    check("hs_run_rst", crst0, 1'b0);
    check("hs_run_busy", busy0, 1'b1);
    check("hs_run_cyc", cyc0, 16'd0);
    done0 = 1'b1;
    ended = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy0) begin
        ended = 1'b1;
        break;
      end
    end
    check("hs_ended", ended, 1'b1);
    check("hs_fin", fin0, 1'b1);
    check("hs_done_rst", crst0, 1'b1);
    done0 = 1'b0;

    // ---- table-driven runs ----
    vecs[0] = '{0, 100, 16'd100, 1'b0, 8'h00, FEAT ? 64 : 0};
    vecs[1] = '{0, 3,   16'd3,   1'b0, 8'h00, FEAT ? 64 : 0};
    vecs[2] = '{1, 5,   16'd5,   1'b0, FEAT ? 8'hFF : 8'h00, FEAT ? 32 : 0};
    vecs[3] = '{1, 19,  16'd19,  1'b0, FEAT ? 8'hFF : 8'h00, FEAT ? 32 : 0};
    vecs[4] = '{1, -1,  16'd20,  1'b1, 8'h00, 0};
    vecs[5] = '{1, 0,   16'd0,   1'b0, FEAT ? 8'hFF : 8'h00, FEAT ? 32 : 0};
    vecs[6] = '{1, 18,  16'd18,  1'b0, FEAT ? 8'hFF : 8'h00, FEAT ? 32 : 0};

    foreach (vecs[v]) begin
      start_and_wait_req(vecs[v].d, ok);
      check($sformatf("v%0d_req_seen", v), ok, 1'b1);
      ended = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (k == vecs[v].done_at) begin
          set_done(vecs[v].d, 1'b1);
          @(negedge clk);
          ended = 1'b1;
          break;
        end
        o = get_obs(vecs[v].d);
        if (!o.busy) begin
          ended = 1'b1;
          break;
        end
      end
      check($sformatf("v%0d_run_ended", v), ended, 1'b1);
      n = 0;
      o = get_obs(vecs[v].d);
      while (o.busy && n < 600) begin
        @(negedge clk);
        n++;
        o = get_obs(vecs[v].d);
      end
      check($sformatf("v%0d_dump_len", v), n, vecs[v].exp_dump);
      check($sformatf("v%0d_fin", v), o.fin, 1'b1);
      check($sformatf("v%0d_cycles", v), o.cyc, vecs[v].exp_cyc);
      check($sformatf("v%0d_timed_out", v), o.to, vecs[v].exp_to);
      check($sformatf("v%0d_checksum", v), o.sum, vecs[v].exp_sum);
      set_done(vecs[v].d, 1'b0);
      @(negedge clk);
      o = get_obs(vecs[v].d);
      check($sformatf("v%0d_hold_fin", v), o.fin, 1'b1);
      check($sformatf("v%0d_hold_cycles", v), o.cyc, vecs[v].exp_cyc);
    end

    // ---- start held high: no restart until DONE, then results cleared ----
    start1 = 1'b1;
    reqs = 0;
    ended = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req1) reqs++;
      if (fin1) begin
        ended = 1'b1;
        break;
      end
    end
    check("hold_reached_done", ended, 1'b1);
    check("hold_req_pulses", reqs, 1);
    check("hold_to", to1, 1'b1);
    check("hold_cyc", cyc1, 16'd20);
    @(negedge clk);
    check("hold_restart_busy", busy1, 1'b1);
    check("hold_restart_fin", fin1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req1) begin
        ok = 1'b1;
        break;
      end
    end
    check("hold_req2_seen", ok, 1'b1);
    start1 = 1'b0;
    @(negedge clk);
    check("hold_clr_cyc", cyc1, 16'd0);
    check("hold_clr_to", to1, 1'b0);
    done1 = 1'b1;
    ended = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fin1) begin
        ended = 1'b1;
        break;
      end
    end
    check("hold_run2_done", ended, 1'b1);
    check("hold_run2_cyc", cyc1, 16'd0);
    check("hold_run2_to", to1, 1'b0);
    done1 = 1'b0;

    // ---- read-back address sequence F0..FF,00..0F ----
    start_and_wait_req(1, ok);
    check("addr_req_seen", ok, 1'b1);
    @(negedge clk);
    check("addr_in_run", addr1, 8'hF0);
    @(negedge clk);
    done1 = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy1 && n < 100) begin
      check($sformatf("addr_seq%0d", n), addr1, 8'(8'hF0 + n));
      n++;
      @(negedge clk);
    end
    check("addr_seq_len", n, FEAT ? 32 : 0);
    check("addr_in_done", addr1, 8'hF0);
    done1 = 1'b0;

    // ---- asynchronous reset in the middle of DUMP (RUN without read-back) ----
    start_and_wait_req(0, ok);
    check("mid_req_seen", ok, 1'b1);
    @(negedge clk);
    if (FEAT) done0 = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_busy", busy0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals("mid", 0, 8'h00);
    check_reset_vals("mid1", 1, 8'hF0);
    @(negedge clk);
    done0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_idle", busy0, 1'b0);
    check("post_reset_fin", fin0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16'd50000, meaning the maximum RUN cycles before abort.
REQ-002 The module SHALL have parameter RD_BASE, default 8'd0, meaning the first data-memory address read back after a run.
REQ-003 The module SHALL have parameter RD_LEN, default 8'd64, meaning the number of bytes read back (1..256, where 0 encodes 256).
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The module SHALL have port start, input, 1, meaning a host request to run one program.
REQ-007 The module SHALL have port cpu_done, input, 1, meaning the core's done flag.
REQ-008 The module SHALL have port cpu_req, output, 1, meaning the core's req input.
REQ-009 The module SHALL have port cpu_rst, output, 1, meaning the core's active-high synchronous reset.
REQ-010 The module SHALL have port mem_addr, output, 8, meaning the data-memory read address.
REQ-011 The module SHALL have port mem_rd_data, input, 8, meaning the asynchronous read data for mem_addr.
REQ-012 The module SHALL have port busy, output, 1, meaning high in every state except IDLE and DONE.
REQ-013 The module SHALL have port finished, output, 1, meaning high in DONE.
REQ-014 The module SHALL have port timed_out, output, 1, meaning the last run hit TIMEOUT.
REQ-015 The module SHALL have port cycles, output, 16, meaning the RUN cycle count of the last run.
REQ-016 The module SHALL have port checksum, output, 8, meaning the XOR of the read-back bytes.

Function
REQ-017 The FSM SHALL have states IDLE, RST, REQ, RUN, DUMP, DONE.
REQ-018 IDLE: cpu_rst=1 and cpu_req=0; start=1 moves to RST.
REQ-019 RST: cpu_rst=1 for exactly 2 cycles, then move to REQ.
REQ-020 REQ: cpu_rst=0 and cpu_req=1 for exactly 1 cycle; clear cycles, checksum and timed_out; then move to RUN.
REQ-021 RUN: cpu_rst=0 and cpu_req=0; cycles increments each cycle and saturates at 16'hFFFF.
REQ-022 RUN: cpu_done=1 moves to DUMP; cycles is not incremented that cycle.
REQ-023 RUN: when cycles==TIMEOUT-1 and cpu_done=0, set timed_out=1 and move to DONE, skipping DUMP.
REQ-024 RUN: cpu_done and the timeout condition in the same cycle SHALL resolve as done, with timed_out=0.
REQ-025 DUMP: mem_addr = RD_BASE + index (8-bit wrap past 255); each cycle checksum ^= mem_rd_data; after RD_LEN bytes, move to DONE.
REQ-026 DUMP: cpu_rst=0 so core memory is preserved.
REQ-027 mem_addr SHALL be RD_BASE outside DUMP.
REQ-028 DONE: cpu_rst=1; results held stable; start=1 moves to RST for a new run, otherwise stay in DONE.
REQ-029 start SHALL be ignored in RST, REQ, RUN and DUMP.
REQ-030 cpu_done SHALL be ignored outside RUN, including a stale high from the previous run.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, cpu_rst=1, cpu_req=0, mem_addr=RD_BASE, busy=0, finished=0, timed_out=0, cycles=0, checksum=0, from any state including mid-RUN or mid-DUMP.
REQ-032 Reset release SHALL take effect on the next clk edge; no start is accepted in the same edge as release.

Configuration
REQ-033 Macro RUN_CTRL_CHECKSUM_EN SHALL select the read-back feature.
REQ-034 With RUN_CTRL_CHECKSUM_EN defined: DUMP as above.
REQ-035 Without RUN_CTRL_CHECKSUM_EN: DUMP is absent, RUN done moves directly to DONE, checksum is tied to 0 and mem_addr to RD_BASE.

Structure
REQ-036 A shared package run_ctrl_pkg SHALL hold the state enum run_state_t and the width constants CYC_W=16 and ADDR_W=8.
REQ-037 One sub-module, run_timer, SHALL implement the saturating cycle counter with clear, enable and terminal-count output.

Verification
REQ-038 Start, done raised after 100 RUN cycles, memory[0..63] = index -> cpu_req high for exactly 1 cycle after 2 cpu_rst cycles; cycles=100; checksum=8'h00; finished=1.
REQ-039 TIMEOUT=20, done never raised -> timed_out=1 and cycles=20 (counted 0..19, then incremented to 20 on the terminal cycle); DUMP skipped; finished=1.
REQ-040 cpu_done and the timeout condition in the same cycle -> timed_out=0 and DUMP is entered.
REQ-041 reset pulsed low mid-DUMP -> all outputs return to reset values immediately, without waiting for clk.
REQ-042 start held high throughout a run -> no restart until DONE; a second run then starts and clears the previous results.
REQ-043 RD_BASE=8'hF0, RD_LEN=32 -> mem_addr sequence F0..FF,00..0F.
